fft_job_scheduler: RTL and testbench
====================================

// Module: fft_job_scheduler
// PURPOSE
//  Shares the single FFT core between two requesters: IFFT jobs (bin BRAM -> core -> DAC
//  playback buffer) and FFT jobs (ADC TX FIFO -> core -> host RX FIFO). Latches host trigger
//  pulses, arbitrates, writes the core config word, feeds one frame, drains one frame, and
//  reports done/errors on wire-out status. Sits between the trigger/BRAM/FIFO fabric and the core.
// PARAMETERS
//  FFT_LEN      1024   frame length in samples (power of 2)
//  SCALE_W      10     scale-schedule width in core config word
//  TIMEOUT_CYC  65536  stall cycles before abort (watchdog only)
// PORTS
//  clk           in   1      system clock, single domain
//  rst           in   1      asynchronous, active-high reset
//  ifft_req      in   1      1-cycle pulse: start IFFT job
//  fft_req       in   1      1-cycle pulse: start FFT job
//  scale_sch     in   SCALE_W scale schedule, sampled at grant
//  bin_rd_addr   out  10     bin BRAM address (1-cycle read latency)
//  bin_rd_data   in   32     {imag[15:0], real[15:0]}
//  txf_dout      in   16     TX FIFO data, first-word-fall-through, signed real
//  txf_empty     in   1      TX FIFO empty
//  txf_rd_en     out  1      TX FIFO pop
//  cfg_tdata     out  16     core config {0, scale_sch, fwd_inv}
//  cfg_tvalid    out  1 / cfg_tready in 1
//  s_tdata       out  32     core input sample; s_tvalid out 1, s_tlast out 1, s_tready in 1
//  m_tdata       in   32     core output sample; m_tvalid in 1, m_tlast in 1, m_tready out 1
//  dac_we        out  1 / dac_waddr out 10 / dac_wdata out 16 (real part)
//  rxf_wr_en     out  1 / rxf_din out 32 / rxf_full in 1
//  busy          out  1      job in progress
//  owner         out  1      0=FFT, 1=IFFT (valid while busy)
//  done          out  1      1-cycle pulse at job end
//  err_tlast     out  1      sticky: m_tlast at wrong beat; cleared at next grant
//  err_timeout   out  1      sticky: watchdog abort; cleared at next grant
// BEHAVIOUR
//  - Reset: all outputs 0, pending flags 0, state IDLE, last_owner=IFFT. Reset mid-job aborts
//    instantly; core itself is reset separately by host.
//  - Requests set pending bit (duplicates merge, also accepted while busy). IDLE grants next
//    cycle; both pending -> grant opposite of last_owner. Grant clears that pending bit.
//  - FSM: IDLE -> CFG -> FEED -> DRAIN -> DONE -> IDLE.
//  - CFG: cfg_tdata={5'b0,scale_sch,fwd_inv}, fwd_inv=1 FFT, 0 IFFT; cfg_tvalid held to handshake.
//  - FEED: in_cnt 0..FFT_LEN-1, advances on s_tvalid&s_tready; s_tlast when in_cnt==FFT_LEN-1.
//    IFFT: BRAM reads via skid buffer, no beat lost under s_tready stalls.
//    FFT: s_tvalid=!txf_empty; s_tdata={16'h0,txf_dout}; txf_rd_en=s_tvalid&s_tready.
//  - DRAIN: m_tready = IFFT ? 1 : !rxf_full. Per beat: IFFT dac_we, dac_waddr=out_cnt,
//    dac_wdata=m_tdata[15:0]; FFT rxf_wr_en, rxf_din=m_tdata. m_tlast at out_cnt==FFT_LEN-1 ->
//    DONE; m_tlast earlier -> err_tlast, DONE; no m_tlast at last beat -> err_tlast, DONE.
//  - DONE: done=1 one cycle, busy falls same edge, last_owner=owner.
//  - Counters are log2(FFT_LEN) bits, no wrap beyond one frame.
// CONFIGURATION
//  FFT_SCHED_TIMEOUT_EN defined: stall counter in CFG/FEED/DRAIN, cleared on any handshake;
//    reaching TIMEOUT_CYC -> err_timeout=1, state IDLE, no done pulse.
//  Undefined: no counter, err_timeout tied 0, scheduler waits indefinitely.
// STRUCTURE
//  fft_sched_pkg: state enum, owner enum, FFT_LEN default, cfg field offsets, fwd_inv encodings.
//  Sub-module axis_skid2: 2-entry skid buffer turning BRAM 1-cycle read into AXI-stream.
// TESTING
//  1 rst, ifft_req, scale_sch=10'h2AB -> cfg_tdata=16'h0556 once; 1024 beats, addr 0..1023,
//    s_tlast on beat 1023; 1024 dac_we, waddr 0..1023; done one cycle; busy low.
//  2 fft_req and ifft_req same cycle after rst -> FFT job (cfg bit0=1) first, IFFT after.
//  3 FFT job, txf_empty toggles every 3 cycles -> exactly 1024 txf_rd_en, tlast on 1024th.
//  4 rxf_full high 50 cycles mid-DRAIN -> m_tready low, no rxf_wr_en, 1024 words total.
//  5 core m_tlast at beat 511 -> err_tlast=1, done; cleared at next grant.
//  6 TIMEOUT_CYC=64, s_tready low in FEED -> err_timeout after 64 cycles, IDLE; macro off: stays FEED.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared types and config-word layout for the FFT job scheduler.
package fft_sched_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_CFG, ST_FEED, ST_DRAIN, ST_DONE} state_e;
    typedef enum logic {OWN_FFT = 1'b0, OWN_IFFT = 1'b1} owner_e;
    localparam int FFT_LEN_DEF   = 1024;
    localparam int SCALE_W_DEF   = 10;
    localparam int TIMEOUT_DEF   = 65536;
    localparam int CFG_W         = 16;
    localparam int CFG_FWD_BIT   = 0;
    localparam int CFG_SCALE_LSB = 1;
    localparam logic FWD_INV_FFT  = 1'b1;
    localparam logic FWD_INV_IFFT = 1'b0;
    function automatic logic fwd_inv_of(input owner_e o);
        return (o == OWN_FFT) ? FWD_INV_FFT : FWD_INV_IFFT;
    endfunction
endpackage

// File: rtl/fft_job_scheduler_skid.sv
// axis_skid2: 2-entry buffer turning a 1-cycle-latency BRAM read into an AXI-stream source.
module axis_skid2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         more_i,
    input  logic [W-1:0] rd_data_i,
    input  logic         tready_i,
    output logic         rd_issue_o,
    output logic [W-1:0] tdata_o,
    output logic         tvalid_o
);
    logic [W-1:0] mem_q [2];
    logic         wp_q, rp_q, inflight_q, pop;
    logic [1:0]   cnt_q;
    logic [2:0]   occ;
    assign tvalid_o = cnt_q != 2'd0;
    assign tdata_o  = mem_q[rp_q];
    assign pop      = tvalid_o && tready_i;
    // Occupancy after this cycle; a new read may only launch if its data will fit.
    assign occ        = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign rd_issue_o = more_i && !clr_i && occ < 3'd2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else if (clr_i) begin
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue_o;
            if (inflight_q) wp_q <= ~wp_q;
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (inflight_q && !clr_i) mem_q[wp_q] <= rd_data_i;
    end
endmodule

// File: rtl/fft_job_scheduler.sv
// fft_job_scheduler: arbitrates IFFT/FFT jobs onto one FFT core (config, feed, drain, status).
// Optional watchdog abort enabled by defining FFT_SCHED_TIMEOUT_EN.
module fft_job_scheduler
    import fft_sched_pkg::*;
#(
    parameter int FFT_LEN     = FFT_LEN_DEF,
    parameter int SCALE_W     = SCALE_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    localparam int AW         = $clog2(FFT_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifft_req,
    input  logic               fft_req,
    input  logic [SCALE_W-1:0] scale_sch,
    output logic [AW-1:0]      bin_rd_addr,
    input  logic [31:0]        bin_rd_data,
    input  logic [15:0]        txf_dout,
    input  logic               txf_empty,
    output logic               txf_rd_en,
    output logic [15:0]        cfg_tdata,
    output logic               cfg_tvalid,
    input  logic               cfg_tready,
    output logic [31:0]        s_tdata,
    output logic               s_tvalid,
    output logic               s_tlast,
    input  logic               s_tready,
    input  logic [31:0]        m_tdata,
    input  logic               m_tvalid,
    input  logic               m_tlast,
    output logic               m_tready,
    output logic               dac_we,
    output logic [AW-1:0]      dac_waddr,
    output logic [15:0]        dac_wdata,
    output logic               rxf_wr_en,
    output logic [31:0]        rxf_din,
    input  logic               rxf_full,
    output logic               busy,
    output logic               owner,
    output logic               done,
    output logic               err_tlast,
    output logic               err_timeout
);
    state_e         state_q;
    owner_e         owner_q, last_owner_q, pick;
    logic [1:0]     pend_q, pend_clr;
    logic [15:0]    cfg_data_q, cfg_word;
    logic [AW-1:0]  in_cnt_q, out_cnt_q, rd_cnt_q;
    logic           rd_all_q, cfg_valid_q, busy_q, done_q, err_tlast_q, err_to_q;
    logic           feed, drain, is_ifft, grant, cfg_hs, s_hs, m_hs, last_out, timeout;
    logic           sk_tvalid, rd_issue;
    logic [31:0]    sk_tdata;
    assign feed     = state_q == ST_FEED;
    assign drain    = state_q == ST_DRAIN;
    assign is_ifft  = owner_q == OWN_IFFT;
    assign grant    = state_q == ST_IDLE && pend_q != 2'b00;
    // pend_q[1] = IFFT, pend_q[0] = FFT; a tie goes to whoever did not run last.
    assign pick     = (pend_q[1] && (!pend_q[0] || last_owner_q == OWN_FFT)) ? OWN_IFFT : OWN_FFT;
    assign pend_clr = grant ? (pick == OWN_IFFT ? 2'b10 : 2'b01) : 2'b00;
    assign cfg_word = (16'(scale_sch) << CFG_SCALE_LSB) | (16'(fwd_inv_of(pick)) << CFG_FWD_BIT);
    assign cfg_hs   = cfg_valid_q && cfg_tready;
    assign s_tvalid = feed && (is_ifft ? sk_tvalid : !txf_empty);
    assign s_tdata  = is_ifft ? sk_tdata : {16'h0, txf_dout};
    assign s_tlast  = feed && in_cnt_q == AW'(FFT_LEN - 1);
    assign s_hs     = s_tvalid && s_tready;
    assign txf_rd_en = s_hs && !is_ifft;
    assign m_tready = drain && (is_ifft || !rxf_full);
    assign m_hs     = m_tvalid && m_tready;
    assign last_out = out_cnt_q == AW'(FFT_LEN - 1);
    assign dac_we    = m_hs && is_ifft;
    assign dac_waddr = out_cnt_q;
    assign dac_wdata = m_tdata[15:0];
    assign rxf_wr_en = m_hs && !is_ifft;
    assign rxf_din   = m_tdata;
    assign bin_rd_addr = rd_cnt_q;
    assign cfg_tdata   = cfg_data_q;
    assign cfg_tvalid  = cfg_valid_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign done        = done_q;
    assign err_tlast   = err_tlast_q;
    assign err_timeout = err_to_q;
    axis_skid2 #(.W(32)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (!feed),
        .more_i     (feed && is_ifft && !rd_all_q),
        .rd_data_i  (bin_rd_data),
        .tready_i   (s_tready && is_ifft),
        .rd_issue_o (rd_issue),
        .tdata_o    (sk_tdata),
        .tvalid_o   (sk_tvalid)
    );
`ifdef FFT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] stall_q;
    logic          active, any_hs;
    assign active  = state_q == ST_CFG || feed || drain;
    assign any_hs  = cfg_hs || s_hs || m_hs;
    assign timeout = active && !any_hs && stall_q == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else stall_q <= (!active || any_hs) ? '0 : stall_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FFT;
            last_owner_q <= OWN_IFFT;
            pend_q       <= 2'b00;
            cfg_data_q   <= '0;
            cfg_valid_q  <= 1'b0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            rd_all_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_tlast_q  <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | {ifft_req, fft_req};
            done_q <= 1'b0;
            if (s_hs) in_cnt_q <= in_cnt_q + 1'b1;
            if (m_hs) out_cnt_q <= out_cnt_q + 1'b1;
            if (rd_issue) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                rd_all_q <= rd_all_q | (rd_cnt_q == AW'(FFT_LEN - 1));
            end
            if (timeout) begin
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                cfg_valid_q <= 1'b0;
                err_to_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: if (grant) begin
                        state_q     <= ST_CFG;
                        owner_q     <= pick;
                        busy_q      <= 1'b1;
                        err_tlast_q <= 1'b0;
                        err_to_q    <= 1'b0;
                        cfg_data_q  <= cfg_word;
                        cfg_valid_q <= 1'b1;
                        in_cnt_q    <= '0;
                        out_cnt_q   <= '0;
                        rd_cnt_q    <= '0;
                        rd_all_q    <= 1'b0;
                    end
                    ST_CFG: if (cfg_hs) begin
                        cfg_valid_q <= 1'b0;
                        state_q     <= ST_FEED;
                    end
                    ST_FEED: if (s_hs && s_tlast) state_q <= ST_DRAIN;
                    // Early tlast or missing tlast both end the job with an error flag.
                    ST_DRAIN: if (m_hs && (m_tlast || last_out)) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        err_tlast_q <= err_tlast_q | (m_tlast != last_out);
                    end
                    ST_DONE: begin
                        state_q      <= ST_IDLE;
                        last_owner_q <= owner_q;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft_job_scheduler.sv
// tb_fft_job_scheduler: directed job sequence with random handshakes against a frame-level model.
module tb_fft_job_scheduler;
    localparam int N = 1024;
    localparam logic [31:0] KEY = 32'h5A5A_1234;
    logic clk = 1'b0, rst = 1'b1;
    logic ifft_req = 0, fft_req = 0;
    logic [9:0] scale_sch = '0;
    logic [9:0] bin_rd_addr, dac_waddr;
    logic [31:0] bin_rd_data = '0, s_tdata, m_tdata, rxf_din;
    logic [15:0] txf_dout, cfg_tdata, dac_wdata;
    logic txf_empty, txf_rd_en, cfg_tvalid, cfg_tready = 0, s_tvalid, s_tlast, s_tready = 0;
    logic m_tvalid, m_tlast, m_tready, dac_we, rxf_wr_en, rxf_full = 0;
    logic busy, owner, done, err_tlast, err_timeout;
    int total = 0, bad = 0;
    logic mon_clr = 0, s_stall = 0, gate_mode = 0, tx_gate = 0;
    int tlast_at = N - 1;
    logic [31:0] bin_mem [N];
    logic [15:0] tx_mem [N];
    logic [10:0] tx_rp = '0;
    logic [31:0] s_cap [N];
    int s_n = 0, s_last_cnt = 0, s_last_idx = -1, m_i = 0, cfg_n = 0, cyc = 0;
    logic out_active = 0, mv_q = 0;
    logic [15:0] cfg_val = '0;
    logic [9:0] dac_addr_log [N];
    logic [15:0] dac_data_log [N];
    logic [31:0] rx_log [N];
    int dac_n = 0, rx_n = 0, full_viol = 0, done_n = 0, done_wide = 0;
    logic done_d = 0;

    always #5 clk = ~clk;

    fft_job_scheduler #(.FFT_LEN(N), .SCALE_W(10), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .ifft_req(ifft_req), .fft_req(fft_req), .scale_sch(scale_sch),
        .bin_rd_addr(bin_rd_addr), .bin_rd_data(bin_rd_data),
        .txf_dout(txf_dout), .txf_empty(txf_empty), .txf_rd_en(txf_rd_en),
        .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .dac_we(dac_we), .dac_waddr(dac_waddr), .dac_wdata(dac_wdata),
        .rxf_wr_en(rxf_wr_en), .rxf_din(rxf_din), .rxf_full(rxf_full),
        .busy(busy), .owner(owner), .done(done), .err_tlast(err_tlast), .err_timeout(err_timeout)
    );

    // Environment: BRAM, first-word-fall-through TX FIFO, and a core that echoes input ^ KEY.
    always @(posedge clk) bin_rd_data <= bin_mem[bin_rd_addr];
    assign txf_empty = tx_gate || tx_rp >= 11'(N);
    assign txf_dout  = tx_mem[tx_rp[9:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        tx_gate <= gate_mode && ((cyc / 3) % 2 == 0);
        if (mon_clr) tx_rp <= '0;
        else if (txf_rd_en) tx_rp <= tx_rp + 1'b1;
    end
    assign m_tvalid = out_active && mv_q;
    assign m_tdata  = s_cap[m_i[9:0]] ^ KEY;
    assign m_tlast  = m_i == tlast_at;
    always @(posedge clk) begin
        cfg_tready <= $urandom % 4 != 0;
        s_tready   <= !s_stall && ($urandom % 4 != 0);
        mv_q       <= $urandom % 4 != 0;
        if (mon_clr) cfg_n <= 0;
        else if (cfg_tvalid && cfg_tready) begin
            if (cfg_n == 0) cfg_val <= cfg_tdata;
            cfg_n <= cfg_n + 1;
        end
        if (cfg_tvalid && cfg_tready) begin
            s_n <= 0; m_i <= 0; out_active <= 0; s_last_cnt <= 0; s_last_idx <= -1;
        end else begin
            if (s_tvalid && s_tready) begin
                if (s_n < N) s_cap[s_n] <= s_tdata;
                if (s_tlast) begin s_last_cnt <= s_last_cnt + 1; s_last_idx <= s_n; end
                if (s_n == N - 1) out_active <= 1;
                s_n <= s_n + 1;
            end
            if (m_tvalid && m_tready) begin
                if (m_tlast || m_i == N - 1) out_active <= 0;
                m_i <= m_i + 1;
            end
        end
    end
    always @(posedge clk) begin
        done_d <= done;
        if (mon_clr) begin
            dac_n <= 0; rx_n <= 0; full_viol <= 0; done_n <= 0; done_wide <= 0;
        end else begin
            if (dac_we && dac_n < N) begin dac_addr_log[dac_n] <= dac_waddr; dac_data_log[dac_n] <= dac_wdata; end
            if (dac_we) dac_n <= dac_n + 1;
            if (rxf_wr_en && rx_n < N) rx_log[rx_n] <= rxf_din;
            if (rxf_wr_en) rx_n <= rx_n + 1;
            if ((rxf_wr_en || m_tready) && rxf_full && !owner) full_viol <= full_viol + 1;
            if (done) done_n <= done_n + 1;
            if (done && done_d) done_wide <= done_wide + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic clr_mon();
        mon_clr = 1; @(negedge clk); mon_clr = 0;
    endtask
    task automatic do_reset();
        @(negedge clk); rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    endtask
    task automatic pulse(input logic i, input logic f);
        @(negedge clk); ifft_req = i; fft_req = f; @(negedge clk); ifft_req = 0; fft_req = 0;
    endtask
    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 12000 && !seen; i++) begin @(negedge clk); seen = done; end
        chk(tag, 32'(seen), 1);
    endtask
    task automatic wait_busy(input string tag);
        bit seen = busy;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = busy; end
        chk(tag, 32'(seen), 1);
    endtask
    // Frame-level expectations: input = source order, output = core echo in beat order.
    task automatic check_ifft(input string tag, input int beats);
        int e = 0;
        logic [31:0] t;
        for (int k = 0; k < beats; k++) begin
            t = bin_mem[k] ^ KEY;
            if (s_cap[k] !== bin_mem[k] || dac_addr_log[k] !== 10'(k) || dac_data_log[k] !== t[15:0]) e++;
        end
        chk({tag, "_data"}, 32'(e), 0);
        chk({tag, "_dac_n"}, 32'(dac_n), 32'(beats));
    endtask
    task automatic check_fft(input string tag);
        int e = 0;
        for (int k = 0; k < N; k++)
            if (s_cap[k] !== {16'h0, tx_mem[k]} || rx_log[k] !== ({16'h0, tx_mem[k]} ^ KEY)) e++;
        chk({tag, "_data"}, 32'(e), 0);
        chk({tag, "_rx_n"}, 32'(rx_n), 32'(N));
        chk({tag, "_pops"}, 32'(tx_rp), 32'(N));
        chk({tag, "_tlast_idx"}, 32'(s_last_idx), 32'(N - 1));
    endtask

    initial begin
        int rx0, tr_hi;
        for (int k = 0; k < N; k++) begin bin_mem[k] = $urandom; tx_mem[k] = 16'($urandom); end
        tx_rp = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg_tvalid", 32'(cfg_tvalid), 0);
        chk("rst_s_tvalid", 32'(s_tvalid), 0);
        chk("rst_errs", {30'(0), err_tlast, err_timeout}, 0);
        chk("rst_wr", {29'(0), dac_we, rxf_wr_en, txf_rd_en}, 0);
        rst = 0;
        // 1: IFFT job
        clr_mon(); scale_sch = 10'h2AB; pulse(1, 0);
        wait_busy("t1_busy");
        chk("t1_owner", 32'(owner), 1);
        wait_done("t1_done");
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_cfg_n", 32'(cfg_n), 1);
        chk("t1_cfg_val", 32'(cfg_val), 32'h0556);
        chk("t1_s_n", 32'(s_n), N);
        chk("t1_tlast_cnt", 32'(s_last_cnt), 1);
        chk("t1_tlast_idx", 32'(s_last_idx), N - 1);
        check_ifft("t1", N);
        chk("t1_err", {30'(0), err_tlast, err_timeout}, 0);
        @(negedge clk); chk("t1_done_width", 32'(done_wide + 32'(done)), 0);
        // 2: simultaneous requests after reset -> FFT first, then IFFT
        do_reset(); clr_mon(); scale_sch = 10'h155; pulse(1, 1);
        wait_busy("t2_busy");
        chk("t2_owner_fft", 32'(owner), 0);
        wait_done("t2_fft_done");
        chk("t2_fwd_inv", 32'(cfg_val[0]), 1);
        check_fft("t2");
        clr_mon();
        wait_busy("t2_busy2");
        chk("t2_owner_ifft", 32'(owner), 1);
        wait_done("t2_ifft_done");
        chk("t2_fwd_inv2", 32'(cfg_val[0]), 0);
        chk("t2_cfg_scale", 32'(cfg_val[10:1]), 32'h155);
        check_ifft("t2i", N);
        // 3: FFT with a bursty TX FIFO
        clr_mon(); gate_mode = 1; pulse(0, 1);
        wait_done("t3_done");
        gate_mode = 0;
        check_fft("t3");
        chk("t3_tlast_cnt", 32'(s_last_cnt), 1);
        // 4: RX FIFO full for 50 cycles mid-drain
        clr_mon(); pulse(0, 1);
        for (int i = 0; i < 12000 && rx_n < 300; i++) @(negedge clk);
        chk("t4_reached_drain", 32'(rx_n >= 300), 1);
        rxf_full = 1; rx0 = rx_n; tr_hi = 0;
        repeat (50) begin @(negedge clk); if (m_tready) tr_hi++; end
        chk("t4_tready_low", 32'(tr_hi), 0);
        chk("t4_no_writes", 32'(rx_n), 32'(rx0));
        rxf_full = 0;
        wait_done("t4_done");
        check_fft("t4");
        chk("t4_full_viol", 32'(full_viol), 0);
        // 5: early tlast at beat 511, then cleared at next grant
        clr_mon(); tlast_at = 511; pulse(1, 0);
        wait_done("t5_done");
        chk("t5_err_tlast", 32'(err_tlast), 1);
        check_ifft("t5", 512);
        clr_mon(); tlast_at = N - 1; pulse(0, 1);
        wait_busy("t5_busy");
        chk("t5_err_cleared", 32'(err_tlast), 0);
        wait_done("t5_done2");
        check_fft("t5f");
        // 5b: tlast never asserted -> error at final beat
        clr_mon(); tlast_at = 5000; pulse(1, 0);
        wait_done("t5b_done");
        chk("t5b_err_tlast", 32'(err_tlast), 1);
        check_ifft("t5b", N);
        tlast_at = N - 1;
        // 6: s_tready stuck low in FEED
        clr_mon(); s_stall = 1; pulse(1, 0);
        repeat (200) @(negedge clk);
`ifdef FFT_SCHED_TIMEOUT_EN
        chk("t6_err_timeout", 32'(err_timeout), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_no_done", 32'(done_n), 0);
        s_stall = 0; clr_mon(); pulse(1, 0);
        wait_busy("t6_busy2");
        chk("t6_timeout_cleared", 32'(err_timeout), 0);
        wait_done("t6_done");
`else
        chk("t6_err_timeout", 32'(err_timeout), 0);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_no_beats", 32'(s_n), 0);
        chk("t6_no_done", 32'(done_n), 0);
        s_stall = 0;
        wait_done("t6_done");
`endif
        check_ifft("t6", N);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
